// File: rtl/tone_player.sv
// Note player: square wave and phase ramp per requested note, with ms timing and a silent gap.
// Optional TONE_QUEUE_EN adds a one-entry holding register so notes can queue behind the current one.
module tone_player #(
  parameter int unsigned TICK_DIV = 31500,
  parameter int unsigned DUR_W    = 12,
  parameter int unsigned GAP_MS   = 20,
  parameter int unsigned OCT_W    = 2
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             note_valid,
  output logic             note_ready,
  input  logic [3:0]       tone,
  input  logic [OCT_W-1:0] octave,
  input  logic [DUR_W-1:0] duration,
  input  logic             mute,
  output logic             sound,
  output logic [7:0]       sample,
  output logic [9:0]       preScaleValue,
  output logic             busy,
  output logic             note_done
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned GW = (GAP_MS > 1) ? $clog2(GAP_MS) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StPlay = 2'd1;
  localparam logic [1:0] StGap  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [9:0]       div_q, div_d;
  logic [9:0]       pre_q, pre_d;
  logic [7:0]       phase_q, phase_d;
  logic [TW-1:0]    tick_q, tick_d;
  logic [DUR_W-1:0] rem_q, rem_d;
  logic [GW-1:0]    gap_q, gap_d;

  logic             accept, tick, gap_end, start, playing;
  logic [3:0]       src_tone;
  logic [OCT_W-1:0] src_oct;
  logic [DUR_W-1:0] src_dur;

  // Octave-4 divisor shifted down by octave with round-half-up, never below 2.
  function automatic logic [9:0] calc_div(input logic [3:0] t, input logic [OCT_W-1:0] o);
    logic [8:0]  base;
    int unsigned half;
    int unsigned res;
    unique case (t)
      4'd0:  base = 9'h1D6;
      4'd1:  base = 9'h1BC;
      4'd2:  base = 9'h1A3;
      4'd3:  base = 9'h18B;
      4'd4:  base = 9'h175;
      4'd5:  base = 9'h160;
      4'd6:  base = 9'h14D;
      4'd7:  base = 9'h13A;
      4'd8:  base = 9'h128;
      4'd9:  base = 9'h118;
      4'd10: base = 9'h108;
      4'd11: base = 9'h0F9;
      4'd12: base = 9'h0EB;
      4'd13: base = 9'h0DD;
      4'd14: base = 9'h0D1;
      default: base = 9'h0C5;
    endcase
    half = (32'd1 << o) >> 1;
    res  = (32'(base) + half) >> o;
    if (res < 32'd2) res = 32'd2;
    return res[9:0];
  endfunction

  assign playing = (state_q == StPlay);
  assign busy    = (state_q != StIdle);
  assign accept  = note_valid & note_ready;
  assign tick    = busy && (tick_q == TW'(TICK_DIV - 1));
  assign gap_end = (state_q == StGap) && ((GAP_MS == 0) || (tick && gap_q == GW'(GAP_MS - 1)));

`ifdef TONE_QUEUE_EN
  logic             hold_valid_q;
  logic [3:0]       hold_tone_q;
  logic [OCT_W-1:0] hold_oct_q;
  logic [DUR_W-1:0] hold_dur_q;

  assign note_ready = (state_q == StIdle) | ~hold_valid_q;
  assign src_tone   = hold_valid_q ? hold_tone_q : tone;
  assign src_oct    = hold_valid_q ? hold_oct_q : octave;
  assign src_dur    = hold_valid_q ? hold_dur_q : duration;
  // A note arriving on the last gap cycle with an empty holder starts directly.
  assign start      = ((state_q == StIdle) & accept) | (gap_end & (hold_valid_q | accept));

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hold_valid_q <= 1'b0;
      hold_tone_q  <= '0;
      hold_oct_q   <= '0;
      hold_dur_q   <= '0;
    end else if (gap_end && hold_valid_q) begin
      hold_valid_q <= 1'b0;
    end else if (accept && busy && !gap_end) begin
      hold_valid_q <= 1'b1;
      hold_tone_q  <= tone;
      hold_oct_q   <= octave;
      hold_dur_q   <= duration;
    end
  end
`else
  assign note_ready = (state_q == StIdle);
  assign src_tone   = tone;
  assign src_oct    = octave;
  assign src_dur    = duration;
  assign start      = accept;
`endif

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    pre_d   = pre_q;
    phase_d = phase_q;
    tick_d  = tick_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    if (busy) tick_d = tick ? '0 : tick_q + TW'(1);
    unique case (state_q)
      StPlay: begin
        if (pre_q == div_q - 10'd1) begin
          pre_d   = '0;
          phase_d = phase_q + 8'd1;
        end else begin
          pre_d = pre_q + 10'd1;
        end
        if (tick) begin
          rem_d = rem_q - DUR_W'(1);
          if (rem_q == DUR_W'(1)) begin
            state_d = StGap;
            gap_d   = '0;
          end
        end
      end
      StGap: begin
        if (tick) gap_d = gap_q + GW'(1);
        if (gap_end) begin
          state_d = StIdle;
          tick_d  = '0;
          gap_d   = '0;
        end
      end
      default: ;
    endcase
    if (start) begin
      state_d = (src_dur != '0) ? StPlay : StGap;
      div_d   = calc_div(src_tone, src_oct);
      rem_d   = src_dur;
      pre_d   = '0;
      phase_d = '0;
      tick_d  = '0;
      gap_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= StIdle;
      div_q   <= '0;
      pre_q   <= '0;
      phase_q <= '0;
      tick_q  <= '0;
      rem_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      pre_q   <= pre_d;
      phase_q <= phase_d;
      tick_q  <= tick_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
    end
  end

  assign sound         = playing & ~mute & phase_q[7];
  assign sample        = (playing & ~mute) ? phase_q : 8'd0;
  assign preScaleValue = playing ? div_q : 10'd0;
  assign note_done     = gap_end;

endmodule

// File: tb/tb_tone_player.sv
// Directed bench for tone_player: divisor table, PLAY/GAP timing, reset abort, mute, period.
module tb_tone_player;
  localparam int unsigned TD = 10;
  localparam int unsigned GM = 2;
  localparam int unsigned BOUND = 40000;

  logic        clk = 1'b0;
  logic        resetN;
  logic        note_valid, valid0, mute;
  logic [3:0]  tone;
  logic [1:0]  octave;
  logic [11:0] duration;
  logic        note_ready, sound, busy, note_done;
  logic [7:0]  sample;
  logic [9:0]  psv;
  logic        ready0, sound0, busy0, done0;
  logic [7:0]  sample0;
  logic [9:0]  psv0;

  int checks = 0;
  int errors = 0;

  tone_player #(.TICK_DIV(TD), .DUR_W(12), .GAP_MS(GM), .OCT_W(2)) dut (
    .clk(clk), .resetN(resetN), .note_valid(note_valid), .note_ready(note_ready),
    .tone(tone), .octave(octave), .duration(duration), .mute(mute), .sound(sound),
    .sample(sample), .preScaleValue(psv), .busy(busy), .note_done(note_done)
  );

  tone_player #(.TICK_DIV(TD), .DUR_W(12), .GAP_MS(0), .OCT_W(2)) dut0 (
    .clk(clk), .resetN(resetN), .note_valid(valid0), .note_ready(ready0),
    .tone(tone), .octave(octave), .duration(duration), .mute(mute), .sound(sound0),
    .sample(sample0), .preScaleValue(psv0), .busy(busy0), .note_done(done0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  tone;
    logic [1:0]  oct;
    logic [11:0] dur;
    logic [9:0]  div;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the first cycle after the handshake.
  task automatic send(input logic [3:0] t, input logic [1:0] o, input logic [11:0] d);
    tone = t; octave = o; duration = d; note_valid = 1'b1;
    check("ready_at_send", note_ready, 1);
    @(posedge clk);
    @(negedge clk);
    note_valid = 1'b0;
  endtask

  task automatic finish_note(input logic [11:0] d, input logic [9:0] div, input string tag);
    int n;
    int g;
    check($sformatf("%s_div", tag), psv, (d != 0) ? div : 10'd0);
    check($sformatf("%s_busy", tag), busy, 1);
    n = 0;
    while (psv != 0 && n < BOUND) begin
      n++;
      @(negedge clk);
    end
    check($sformatf("%s_play_len", tag), n, d * TD);
    g = 0;
    while (busy && !note_done && g < BOUND) begin
      g++;
      @(negedge clk);
    end
    check($sformatf("%s_done", tag), note_done, 1);
    check($sformatf("%s_gap_len", tag), g + 1, GM * TD);
    @(negedge clk);
    check($sformatf("%s_idle", tag), {busy, note_done, note_ready}, 3'b001);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < BOUND) begin
      n++;
      @(negedge clk);
    end
    check($sformatf("%s_idle", tag), busy, 0);
  endtask

  initial begin
    int k, r1, r2, flag;
    logic prev;
    vecs[0] = '{4'd9,  2'd0, 12'd3, 10'h118};
    vecs[1] = '{4'd0,  2'd0, 12'd1, 10'h1D6};
    vecs[2] = '{4'd0,  2'd1, 12'd1, 10'h0EB};
    vecs[3] = '{4'd0,  2'd2, 12'd1, 10'h076};
    vecs[4] = '{4'd0,  2'd3, 12'd1, 10'h03B};
    vecs[5] = '{4'd15, 2'd3, 12'd2, 10'h019};
    vecs[6] = '{4'd11, 2'd2, 12'd1, 10'h03E};
    vecs[7] = '{4'd4,  2'd1, 12'd0, 10'h0BB};

    resetN = 1'b0; note_valid = 1'b0; valid0 = 1'b0; mute = 1'b0;
    tone = '0; octave = '0; duration = '0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {note_ready, sound, sample, psv, busy, note_done}, {1'b1, 21'd0});
    resetN = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      send(vecs[i].tone, vecs[i].oct, vecs[i].dur);
      finish_note(vecs[i].dur, vecs[i].div, $sformatf("vec%0d", i));
    end

    // Abort mid-PLAY; ramp is already at 1 so the reset really clears something.
    send(4'd0, 2'd3, 12'd100);
    repeat (100) @(negedge clk);
    check("pre_rst_sample", sample, 1);
    resetN = 1'b0;
    #1;
    check("midrst_outputs", {note_ready, sound, sample, psv, busy, note_done}, {1'b1, 21'd0});
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    send(4'd9, 2'd0, 12'd1);
    finish_note(12'd1, 10'h118, "post_rst");

    // Square-wave period at the lowest divisor of the octave sweep.
    send(4'd0, 2'd3, 12'd2400);
    k = 0; r1 = 0; r2 = 0; prev = 1'b0;
    while (psv != 0 && k < BOUND) begin
      if (k == 295) check("ramp_at_295", sample, 5);
      if (sound && !prev) begin
        if (r1 == 0) r1 = k;
        else if (r2 == 0) r2 = k;
      end
      prev = sound;
      k++;
      @(negedge clk);
    end
    check("first_rise", r1, 7552);
    check("period", r2 - r1, 15104);
    check("long_play_len", k, 24000);
    wait_idle("period");
    @(negedge clk);

    mute = 1'b1;
    send(4'd0, 2'd3, 12'd800);
    k = 0; flag = 0;
    while (psv != 0 && k < BOUND) begin
      if (sound || sample != 0) flag = 1;
      k++;
      @(negedge clk);
    end
    check("mute_silent", flag, 0);
    check("mute_play_len", k, 8000);
    wait_idle("mute");
    mute = 1'b0;
    @(negedge clk);

`ifndef TONE_QUEUE_EN
    // Request held through a whole note must wait for IDLE.
    tone = 4'd9; octave = 2'd0; duration = 12'd3; note_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tone = 4'd13; duration = 12'd1;
    k = 0; flag = 0;
    while (!note_done && k < BOUND) begin
      if (note_ready) flag = 1;
      k++;
      @(negedge clk);
    end
    check("held_ready_low", flag, 0);
    check("held_busy_len", k, 49);
    @(negedge clk);
    check("held_ready_idle", {busy, note_ready}, 2'b01);
    @(posedge clk);
    @(negedge clk);
    note_valid = 1'b0;
    finish_note(12'd1, 10'h0DD, "held2");
`else
    tone = 4'd9; octave = 2'd0; duration = 12'd3; note_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tone = 4'd0; duration = 12'd1;
    check("q_ready_empty", note_ready, 1);
    @(posedge clk);
    @(negedge clk);
    tone = 4'd15; octave = 2'd3; duration = 12'd2;
    check("q_ready_full", note_ready, 0);
    k = 0;
    while (!note_done && k < BOUND) begin
      k++;
      @(negedge clk);
    end
    check("q_first_len", k, 48);
    @(negedge clk);
    check("q_second_div", psv, 10'h1D6);
    check("q_ready_again", note_ready, 1);
    @(posedge clk);
    @(negedge clk);
    note_valid = 1'b0;
    k = 0;
    while (!note_done && k < BOUND) begin
      k++;
      @(negedge clk);
    end
    @(negedge clk);
    check("q_third_div", psv, 10'h019);
    wait_idle("queue");
    @(negedge clk);
`endif

    // Zero-gap instance: a rest is one GAP cycle carrying note_done.
    tone = 4'd9; octave = 2'd0; duration = 12'd0; valid0 = 1'b1;
    check("g0_ready", ready0, 1);
    @(posedge clk);
    @(negedge clk);
    valid0 = 1'b0;
    check("g0_rest_gap", {busy0, done0, sound0, psv0}, {3'b110, 10'd0});
    @(negedge clk);
    check("g0_rest_idle", {busy0, done0, ready0}, 3'b001);
    duration = 12'd1; valid0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid0 = 1'b0;
    k = 0;
    while (psv0 != 0 && k < BOUND) begin
      k++;
      @(negedge clk);
    end
    check("g0_play_len", k, 10);
    check("g0_done", {busy0, done0}, 2'b11);
    @(negedge clk);
    check("g0_idle", {busy0, done0}, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tone_player.md
Name: tone_player

Overview:
Parametrised note player for the audio path: accepts note requests (tone index, octave, duration) over a valid/ready handshake, then plays each note for the requested time. Output is a square wave plus an 8-bit phase ramp for the DAC path, followed by a fixed silent gap between notes. Generalises the single-octave prescale lookup to 4 selectable octaves, adds note timing, sequencing and back-pressure. Sits between the game-sound sequencer and the audio codec interface.

Parameters:
TICK_DIV, 31500, clk cycles per 1 ms tick (31.5 MHz clock)
DUR_W, 12, width of duration field in ms (max 4095 ms)
GAP_MS, 20, silent gap after each note, in ms (0 = no gap)
OCT_W, 2, octave select width; octave 0 = octave 4, each increment +1 octave

Ports:
clk  in  1  system clock, 31.5 MHz
resetN  in  1  asynchronous active-low reset
note_valid  in  1  note request present
note_ready  out  1  player can accept a note
tone  in  4  note index 0..15 (do, doD, re, ... si, do+1, doD+1, re+1, reD+1)
octave  in  OCT_W  octave shift
duration  in  DUR_W  note length in ms; 0 = rest of GAP_MS only
mute  in  1  forces sound/sample low; timing unaffected
sound  out  1  square wave, MSB of phase accumulator
sample  out  8  phase accumulator value (ramp)
preScaleValue  out  10  active prescale divisor (0 when idle)
busy  out  1  high in PLAY or GAP
note_done  out  1  one-cycle pulse when GAP completes

Behaviour:
- Reset (async, resetN=0): state IDLE; all counters 0; note_ready=1, sound=0, sample=0, preScaleValue=0, busy=0, note_done=0.
- Base table (octave 4, index 0..15): 1D6,1BC,1A3,18B,175,160,14D,13A,128,118,108,0F9,0EB,0DD,0D1,0C5 (hex).
- Divisor = base >> octave, rounded: (base + half) >> octave, where half = (1<<octave)>>1; result clamped to minimum 2. Registered at note acceptance.
- Output frequency = clk / (256 * divisor). Prescale counter counts 0..divisor-1. On wrap, the 8-bit phase increments (mod 256).
- ms tick: counter 0..TICK_DIV-1, free-running only while busy; restarts from 0 at note acceptance.
- FSM:
  - IDLE: note_ready=1. note_valid&note_ready -> latch tone/octave/duration; phase=0, prescale=0. Go to PLAY if duration>0, else GAP.
  - PLAY: note_ready=0. Phase advances. Decrement remaining ms on each tick; at remaining==0 after a tick -> GAP. Duration N gives exactly N*TICK_DIV cycles in PLAY.
  - GAP: sound=0, sample=0, preScaleValue=0. After GAP_MS ticks (0 = single cycle) -> IDLE, with note_done=1 for that cycle.
- Acceptance latency: first PLAY cycle is the cycle after the handshake. sound/sample are registered.
- mute=1: sound=0, sample=0 combinationally gated; phase still advances.
- note_valid while not ready: ignored. Source holds the request until accepted.
- resetN low mid-note: immediate abort to IDLE with reset values; no note_done.

Optional Feature:
TONE_QUEUE_EN: when defined, a one-entry holding register is added. note_ready=1 in PLAY/GAP while the holding register is empty. A held note starts on the cycle after note_done, with no IDLE cycle in between. Without the macro, notes are accepted only in IDLE, exactly as above.

Test Plan:
- Reset: assert resetN=0 mid-PLAY -> all outputs 0 at once, note_ready=1; after release, next note accepted normally.
- TICK_DIV=10, GAP_MS=2: tone=9, octave=0, duration=3 -> preScaleValue=0x118, PLAY for 30 cycles, GAP for 20, note_done pulse, back to IDLE.
- Octave math: tone=0 with octave=0/1/2/3 -> preScaleValue 0x1D6, 0xEB, 0x76, 0x3B; sound period = 256*divisor cycles (0x3B -> 15104 cycles).
- duration=0, GAP_MS=0 -> accept, one GAP cycle, note_done the next cycle, sound stays 0.
- note_valid held during PLAY (macro off) -> note_ready=0, no acceptance until IDLE; mute=1 during PLAY -> sound=0 but note ends on the same cycle as unmuted.
- TONE_QUEUE_EN: two back-to-back notes -> second accepted during PLAY of the first, starts the cycle after note_done; third held off until the queue empties.
